// File: rtl/wave_meas.sv
// wave_meas: waveform period / peak-to-peak analyser for 14-bit offset-binary
// sample streams. Rising midscale crossings are detected with a hysteresis
// band; every crossing publishes the sample count and max-min of the window
// since the previous crossing.
// Optional build macro: WAVE_MEAS_AVG_EN -- publish once per four periods
// with the averaged period and the combined peak-to-peak amplitude.
module wave_meas #(
    parameter int PERIOD_W = 24,
    parameter int HYST     = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                sample_valid,
    input  logic [13:0]         sample,
    output logic [PERIOD_W-1:0] period,
    output logic [13:0]         amp_pp,
    output logic                meas_valid,
    output logic                timeout
);

    localparam logic [13:0]         THR_LO  = 14'(8192 - HYST);
    localparam logic [13:0]         THR_HI  = 14'(8192 + HYST);
    localparam logic [PERIOD_W-1:0] CNT_MAX = {PERIOD_W{1'b1}};

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARM     = 3'd1,
        ST_SYNC    = 3'd2,
        ST_MEAS_LO = 3'd3,
        ST_MEAS_HI = 3'd4
    } state_t;

    state_t              state_r, state_nxt_s;
    logic [PERIOD_W-1:0] cnt_r, cnt_nxt_s;
    logic [13:0]         min_r, min_nxt_s;
    logic [13:0]         max_r, max_nxt_s;
    logic [PERIOD_W-1:0] period_nxt_s;
    logic [13:0]         amp_nxt_s;
    logic                meas_valid_nxt_s;
    logic                timeout_nxt_s;
    logic                is_low_s;
    logic                is_high_s;

`ifdef WAVE_MEAS_AVG_EN
    logic [PERIOD_W+1:0] acc_sum_r, acc_sum_nxt_s, acc_total_s;
    logic [1:0]          acc_cnt_r, acc_cnt_nxt_s;
`endif

    function automatic logic [13:0] min14(input logic [13:0] a, input logic [13:0] b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic [13:0] max14(input logic [13:0] a, input logic [13:0] b);
        return (a > b) ? a : b;
    endfunction

    assign is_low_s  = (sample < THR_LO);
    assign is_high_s = (sample >= THR_HI);

    // Next-state and datapath: crossing detection, counting, publishing, saturation.
    always_comb begin
        state_nxt_s      = state_r;
        cnt_nxt_s        = cnt_r;
        min_nxt_s        = min_r;
        max_nxt_s        = max_r;
        period_nxt_s     = period;
        amp_nxt_s        = amp_pp;
        meas_valid_nxt_s = 1'b0;
        timeout_nxt_s    = timeout;
`ifdef WAVE_MEAS_AVG_EN
        acc_sum_nxt_s    = acc_sum_r;
        acc_cnt_nxt_s    = acc_cnt_r;
        acc_total_s      = acc_sum_r + {2'b00, cnt_r};
`endif
        if (!en) begin
            // Disable aborts the measurement; published results stay visible.
            state_nxt_s = ST_IDLE;
            cnt_nxt_s   = {PERIOD_W{1'b0}};
            min_nxt_s   = 14'd0;
            max_nxt_s   = 14'd0;
`ifdef WAVE_MEAS_AVG_EN
            acc_sum_nxt_s = {(PERIOD_W+2){1'b0}};
            acc_cnt_nxt_s = 2'd0;
`endif
        end else if (state_r == ST_IDLE) begin
            state_nxt_s = ST_ARM;
`ifdef WAVE_MEAS_AVG_EN
            acc_sum_nxt_s = {(PERIOD_W+2){1'b0}};
            acc_cnt_nxt_s = 2'd0;
`endif
        end else if (sample_valid) begin
            case (state_r)
                ST_ARM: begin
`ifdef WAVE_MEAS_AVG_EN
                    acc_sum_nxt_s = {(PERIOD_W+2){1'b0}};
                    acc_cnt_nxt_s = 2'd0;
`endif
                    if (is_low_s) begin
                        state_nxt_s = ST_SYNC;
                    end else begin
                        state_nxt_s = ST_ARM;
                    end
                end
                ST_SYNC: begin
                    if (is_high_s) begin
                        // First crossing opens the first window.
                        state_nxt_s = ST_MEAS_LO;
                        cnt_nxt_s   = {{(PERIOD_W-1){1'b0}}, 1'b1};
                        min_nxt_s   = sample;
                        max_nxt_s   = sample;
                    end else begin
                        state_nxt_s = ST_SYNC;
                    end
                end
                ST_MEAS_LO, ST_MEAS_HI: begin
                    if ((state_r == ST_MEAS_HI) && is_high_s) begin
                        // Rising crossing: the crossing sample starts the next window,
                        // so the published window excludes it. Crossing beats saturation.
                        state_nxt_s = ST_MEAS_LO;
                        cnt_nxt_s   = {{(PERIOD_W-1){1'b0}}, 1'b1};
`ifdef WAVE_MEAS_AVG_EN
                        if (acc_cnt_r == 2'd3) begin
                            period_nxt_s     = acc_total_s[PERIOD_W+1:2];
                            amp_nxt_s        = max_r - min_r;
                            meas_valid_nxt_s = 1'b1;
                            timeout_nxt_s    = 1'b0;
                            acc_sum_nxt_s    = {(PERIOD_W+2){1'b0}};
                            acc_cnt_nxt_s    = 2'd0;
                            min_nxt_s        = sample;
                            max_nxt_s        = sample;
                        end else begin
                            // Min/max keep spanning all four periods.
                            acc_sum_nxt_s = acc_total_s;
                            acc_cnt_nxt_s = acc_cnt_r + 2'd1;
                            min_nxt_s     = min14(min_r, sample);
                            max_nxt_s     = max14(max_r, sample);
                        end
`else
                        period_nxt_s     = cnt_r;
                        amp_nxt_s        = max_r - min_r;
                        meas_valid_nxt_s = 1'b1;
                        timeout_nxt_s    = 1'b0;
                        min_nxt_s        = sample;
                        max_nxt_s        = sample;
`endif
                    end else if (cnt_r == CNT_MAX) begin
                        // Counter would overflow: give up and re-arm.
                        state_nxt_s   = ST_ARM;
                        cnt_nxt_s     = {PERIOD_W{1'b0}};
                        min_nxt_s     = 14'd0;
                        max_nxt_s     = 14'd0;
                        timeout_nxt_s = 1'b1;
`ifdef WAVE_MEAS_AVG_EN
                        acc_sum_nxt_s = {(PERIOD_W+2){1'b0}};
                        acc_cnt_nxt_s = 2'd0;
`endif
                    end else begin
                        cnt_nxt_s = cnt_r + {{(PERIOD_W-1){1'b0}}, 1'b1};
                        min_nxt_s = min14(min_r, sample);
                        max_nxt_s = max14(max_r, sample);
                        if ((state_r == ST_MEAS_LO) && is_low_s) begin
                            state_nxt_s = ST_MEAS_HI;
                        end else begin
                            state_nxt_s = state_r;
                        end
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = {PERIOD_W{1'b0}};
                    min_nxt_s   = 14'd0;
                    max_nxt_s   = 14'd0;
                end
            endcase
        end else begin
            // No accepted sample: everything holds.
            state_nxt_s = state_r;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Window counters and registered measurement outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r      <= {PERIOD_W{1'b0}};
            min_r      <= 14'd0;
            max_r      <= 14'd0;
            period     <= {PERIOD_W{1'b0}};
            amp_pp     <= 14'd0;
            meas_valid <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            cnt_r      <= cnt_nxt_s;
            min_r      <= min_nxt_s;
            max_r      <= max_nxt_s;
            period     <= period_nxt_s;
            amp_pp     <= amp_nxt_s;
            meas_valid <= meas_valid_nxt_s;
            timeout    <= timeout_nxt_s;
        end
    end

`ifdef WAVE_MEAS_AVG_EN
    // Four-period accumulator for averaged publishing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_sum_r <= {(PERIOD_W+2){1'b0}};
            acc_cnt_r <= 2'd0;
        end else begin
            acc_sum_r <= acc_sum_nxt_s;
            acc_cnt_r <= acc_cnt_nxt_s;
        end
    end
`endif

endmodule
